// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state encodings, default operand width and a flag-validity helper.
package sar_pkg;

    localparam int unsigned SAR_WIDTH = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Comparator flags {lt, eq, gt} are only trustworthy when exactly one is high.
    function automatic logic flags_onehot(input logic [2:0] flags);
        return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    endfunction

endpackage

// File: rtl/sar_search4.sv
// Successive-approximation search controller: resolves an unknown target one
// bit per clock, MSB first, by driving trials into an external comparator.
module sar_search4
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic [WIDTH-1:0] trial_o,
    input  logic             cmp_lt_i,
    input  logic             cmp_eq_i,
    input  logic             cmp_gt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] trial_q,  trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q,      k_d;
    logic             err_q,    err_d;
    logic             busy_q,   done_q;
    logic [WIDTH-1:0] next_v;
    logic [2:0]       flags;

    // Next-state and datapath decisions.
    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        k_d      = k_q;
        err_d    = err_q;
        next_v   = trial_q;
        flags    = {cmp_lt_i, cmp_eq_i, cmp_gt_i};

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    trial_d = WIDTH'(1) << (WIDTH - 1);
                    k_d     = KW'(WIDTH - 1);
                    err_d   = 1'b0;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (!flags_onehot(flags)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else if (cmp_eq_i) begin
                    result_d = trial_q;
                    state_d  = ST_DONE;
                end else begin
                    if (cmp_lt_i) begin
                        next_v[k_q] = 1'b0;
                    end
                    if (k_q == '0) begin
                        result_d = next_v;
                        state_d  = ST_DONE;
                    end else begin
                        trial_d = next_v | (WIDTH'(1) << (k_q - KW'(1)));
                        k_d     = k_q - KW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; busy/done track the next state so they are
    // aligned with state_q and come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            trial_q  <= '0;
            result_q <= '0;
            k_q      <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            k_q      <= k_d;
            err_q    <= err_d;
            busy_q   <= (state_d == ST_SEARCH);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign trial_o  = trial_q;
    assign result_o = result_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_sar_search4.sv
// Scoreboard bench for sar_search4 against a behavioural 4-bit comparator
// with a flag-override path for fault injection.
module tb_sar_search4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] trial, result;
    logic       cmp_lt, cmp_eq, cmp_gt;
    logic       busy, done, err;

    logic [3:0] target = 4'd0;
    logic       fault_en = 1'b0;
    logic [2:0] fault_flags = 3'b000;

    always #5 clk = ~clk;

    assign cmp_lt = fault_en ? fault_flags[2] : (target <  trial);
    assign cmp_eq = fault_en ? fault_flags[1] : (target == trial);
    assign cmp_gt = fault_en ? fault_flags[0] : (target >  trial);

    sar_search4 #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .trial_o  (trial),
        .cmp_lt_i (cmp_lt),
        .cmp_eq_i (cmp_eq),
        .cmp_gt_i (cmp_gt),
        .result_o (result),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err)
    );

    typedef struct {
        logic [3:0] res;
        logic       err;
        int         lat;
        int         c0;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Start-edge-to-done latency (1 + decisions) per target, worked by hand.
    int lat_tab [16] = '{5, 5, 4, 5, 3, 5, 4, 5, 2, 5, 4, 5, 3, 5, 4, 5};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        int busy_n;
        exp_t e;
        busy_n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy_n = 0;
            end else begin
                if (busy) busy_n++;
                if (done) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("result", int'(result), int'(e.res));
                        chk("err", int'(err), int'(e.err));
                        chk("latency", cyc - e.c0 + 1, e.lat);
                        chk("busy_cycles", busy_n, e.lat - 1);
                    end
                    busy_n = 0;
                end
            end
        end
    end

    task automatic push_exp(input logic [3:0] res, input logic e, input int lat, input int c0);
        exp_t x;
        x.res = res; x.err = e; x.lat = lat; x.c0 = c0;
        sbq.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            chk("done_timeout", 0, 1);
            sbq.delete();
        end
    endtask

    task automatic run(input logic [3:0] t, input logic [3:0] res, input logic e, input int lat);
        @(negedge clk);
        target = t;
        start  = 1'b1;
        push_exp(res, e, lat, cyc + 1);
        @(posedge clk);
        #1;
        chk("err_cleared_on_start", int'(err), 0);
        chk("busy_after_start", int'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    initial begin
        int c0;
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        chk("rst_trial", int'(trial), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Sweep every target; includes 11 (8,12,10,11), 8 (early eq), 0 and 15.
        for (int t = 0; t < 16; t++) begin
            run(4'(t), 4'(t), 1'b0, lat_tab[t]);
        end

        // Fault: lt and gt both high on the second decision.
        @(negedge clk);
        target = 4'd5;
        start  = 1'b1;
        push_exp(4'd0, 1'b1, 3, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        fault_flags = 3'b101;
        fault_en    = 1'b1;
        drain();
        fault_en = 1'b0;
        run(4'd9, 4'd9, 1'b0, 5);

        // Fault: no flag high on the first decision.
        @(negedge clk);
        target      = 4'd3;
        fault_flags = 3'b000;
        fault_en    = 1'b1;
        start       = 1'b1;
        push_exp(4'd0, 1'b1, 2, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        drain();
        fault_en = 1'b0;
        run(4'd3, 4'd3, 1'b0, 5);

        // start held high: accepts only in IDLE, period latency+1 = 5.
        @(negedge clk);
        target = 4'd6;
        start  = 1'b1;
        c0     = cyc + 1;
        push_exp(4'd6, 1'b0, 4, c0);
        push_exp(4'd6, 1'b0, 4, c0 + 5);
        push_exp(4'd6, 1'b0, 4, c0 + 10);
        repeat (11) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        drain();

        // start pulse mid-search is ignored: exactly one done.
        @(negedge clk);
        target = 4'd11;
        start  = 1'b1;
        push_exp(4'd11, 1'b0, 5, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (8) @(negedge clk);

        // Reset after two decisions aborts with no done pulse.
        @(negedge clk);
        target = 4'd13;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_trial", int'(trial), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run(4'd13, 4'd13, 1'b0, 5);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
